// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU decode/issue stage with operand forwarding and output handshake
//
// Decodes one MIPS instruction into ALU controls, forwards a same-cycle write-back
// onto the source operands and holds the result in an output register under a
// valid/ready handshake with flush.
//
// Optional feature: define ALU_MUL_EN to decode op 1C / funct 02 (mul) as 4'b1111.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         input handshake (in_ready is combinational)
//   instr, rs_data, rt_data     instruction and its register-file read data
//   wb_we, wb_addr, wb_data     write-back bus used as forwarding source
//   flush                       drop the held and the incoming instruction
//   out_valid / out_ready       output handshake towards the ALU/EX stage
//   data_a, data_b              ALU operands (forwarded rs / rt)
//   imme, shamt                 raw instruction fields
//   ALUSrc, alu_control         ALU operand-B select and operation code
//   illegal                     issued instruction was undecodable

module alu_issue_stage #(
    parameter int          DATA_W   = 32,
    parameter logic [3:0]  ILL_CODE = 4'b0011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [15:0]       imme,
    output logic [4:0]        shamt,
    output logic              ALUSrc,
    output logic [3:0]        alu_control,
    output logic              illegal
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;

    assign op      = instr[31:26];
    assign funct   = instr[5:0];
    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];

    // Decode
    logic [3:0] dec_ctl;
    logic       dec_src;
    logic       dec_ill;

    always_comb begin
        dec_ctl = ILL_CODE;
        dec_src = 1'b0;
        dec_ill = 1'b1;
        case (op)
            6'h00: begin
                dec_ill = 1'b0;
                case (funct)
                    6'h20, 6'h21: dec_ctl = 4'b0010;
                    6'h22, 6'h23: dec_ctl = 4'b0110;
                    6'h24:        dec_ctl = 4'b0000;
                    6'h25:        dec_ctl = 4'b0001;
                    6'h26:        dec_ctl = 4'b1100;
                    6'h2A:        dec_ctl = 4'b0111;
                    6'h00:        dec_ctl = 4'b1101;
                    6'h02:        dec_ctl = 4'b1110;
                    default: begin
                        dec_ctl = ILL_CODE;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                dec_ctl = 4'b0010;
                dec_src = 1'b1;
                dec_ill = 1'b0;
            end
            6'h0C: begin
                dec_ctl = 4'b0000;
                dec_src = 1'b1;
                dec_ill = 1'b0;
            end
            6'h0D: begin
                dec_ctl = 4'b0001;
                dec_src = 1'b1;
                dec_ill = 1'b0;
            end
            6'h0E: begin
                dec_ctl = 4'b1100;
                dec_src = 1'b1;
                dec_ill = 1'b0;
            end
            6'h0A: begin
                dec_ctl = 4'b0111;
                dec_src = 1'b1;
                dec_ill = 1'b0;
            end
            // beq compares two registers, so operand B stays rt
            6'h04: begin
                dec_ctl = 4'b0110;
                dec_ill = 1'b0;
            end
`ifdef ALU_MUL_EN
            6'h1C: begin
                if (funct == 6'h02) begin
                    dec_ctl = 4'b1111;
                    dec_ill = 1'b0;
                end
            end
`endif
            default: begin
                dec_ctl = ILL_CODE;
                dec_ill = 1'b1;
            end
        endcase
    end

    // Forwarding: register 0 is hard-wired zero and never takes write-back data
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    always_comb begin
        fwd_a = rs_data;
        fwd_b = rt_data;
        if (wb_we && (wb_addr != 5'd0) && (wb_addr == rs_addr)) begin
            fwd_a = wb_data;
        end
        if (wb_we && (wb_addr != 5'd0) && (wb_addr == rt_addr)) begin
            fwd_b = wb_data;
        end
    end

    // Output register and handshake
    logic              out_valid_q,   out_valid_d;
    logic              illegal_q,     illegal_d;
    logic [3:0]        alu_control_q, alu_control_d;
    logic              alu_src_q,     alu_src_d;
    logic [DATA_W-1:0] data_a_q,      data_a_d;
    logic [DATA_W-1:0] data_b_q,      data_b_d;
    logic [15:0]       imme_q,        imme_d;
    logic [4:0]        shamt_q,       shamt_d;
    logic              accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        illegal_d     = illegal_q;
        alu_control_d = alu_control_q;
        alu_src_d     = alu_src_q;
        data_a_d      = data_a_q;
        data_b_d      = data_b_q;
        imme_d        = imme_q;
        shamt_d       = shamt_q;
        if (flush) begin
            // flush only invalidates; payload registers keep their last value
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            illegal_d     = dec_ill;
            alu_control_d = dec_ctl;
            alu_src_d     = dec_src;
            data_a_d      = fwd_a;
            data_b_d      = fwd_b;
            imme_d        = instr[15:0];
            shamt_d       = instr[10:6];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            illegal_q     <= 1'b0;
            alu_control_q <= ILL_CODE;
            alu_src_q     <= 1'b0;
            data_a_q      <= '0;
            data_b_q      <= '0;
            imme_q        <= '0;
            shamt_q       <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            illegal_q     <= illegal_d;
            alu_control_q <= alu_control_d;
            alu_src_q     <= alu_src_d;
            data_a_q      <= data_a_d;
            data_b_q      <= data_b_d;
            imme_q        <= imme_d;
            shamt_q       <= shamt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign illegal     = illegal_q;
    assign alu_control = alu_control_q;
    assign ALUSrc      = alu_src_q;
    assign data_a      = data_a_q;
    assign data_b      = data_b_q;
    assign imme        = imme_q;
    assign shamt       = shamt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [15:0] imme;
    logic [4:0]  shamt;
    logic        ALUSrc;
    logic [3:0]  alu_control;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(32), .ILL_CODE(4'b0011)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .data_a(data_a), .data_b(data_b),
        .imme(imme), .shamt(shamt), .ALUSrc(ALUSrc), .alu_control(alu_control),
        .illegal(illegal)
    );

    // Reference model state: what the output register should show
    logic        m_valid, m_ill, m_src;
    logic [3:0]  m_ctl;
    logic [31:0] m_a, m_b;
    logic [15:0] m_imm;
    logic [4:0]  m_sh;

    logic [91:0] dut_pack;
    assign dut_pack = {out_valid, illegal, alu_control, ALUSrc, data_a, data_b, imme, shamt};

    function automatic logic [91:0] exp_pack();
        return {m_valid, m_ill, m_ctl, m_src, m_a, m_b, m_imm, m_sh};
    endfunction

    // Returns {illegal, ALUSrc, alu_control} from the decode table
    function automatic logic [5:0] ref_decode(input logic [31:0] w);
        logic [5:0] o = w[31:26];
        logic [5:0] f = w[5:0];
        if (o == 6'h00) begin
            if (f inside {6'h20, 6'h21}) return {2'b00, 4'b0010};
            if (f inside {6'h22, 6'h23}) return {2'b00, 4'b0110};
            if (f == 6'h24) return {2'b00, 4'b0000};
            if (f == 6'h25) return {2'b00, 4'b0001};
            if (f == 6'h26) return {2'b00, 4'b1100};
            if (f == 6'h2A) return {2'b00, 4'b0111};
            if (f == 6'h00) return {2'b00, 4'b1101};
            if (f == 6'h02) return {2'b00, 4'b1110};
            return {2'b10, 4'b0011};
        end
        if (o inside {6'h08, 6'h09, 6'h23, 6'h2B}) return {2'b01, 4'b0010};
        if (o == 6'h0C) return {2'b01, 4'b0000};
        if (o == 6'h0D) return {2'b01, 4'b0001};
        if (o == 6'h0E) return {2'b01, 4'b1100};
        if (o == 6'h0A) return {2'b01, 4'b0111};
        if (o == 6'h04) return {2'b00, 4'b0110};
`ifdef ALU_MUL_EN
        if (o == 6'h1C && f == 6'h02) return {2'b00, 4'b1111};
`endif
        return {2'b10, 4'b0011};
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rd);
        if (wb_we && wb_addr != 5'd0 && wb_addr == src) return wb_data;
        return rd;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] rs,
                         input logic [31:0] rt, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic fl, input logic ordy);
        in_valid = v; instr = w; rs_data = rs; rt_data = rt;
        wb_we = we; wb_addr = wa; wb_data = wd; flush = fl; out_ready = ordy;
        #1;
    endtask

    // Advance one clock and move the model by the handshake rules
    task automatic tick();
        logic        nv, ni, ns;
        logic [3:0]  nc;
        logic [31:0] na, nb;
        logic [15:0] nim;
        logic [4:0]  nsh;
        logic [5:0]  d;
        nv = m_valid; ni = m_ill; ns = m_src; nc = m_ctl;
        na = m_a; nb = m_b; nim = m_imm; nsh = m_sh;
        if (!rst_n) begin
            nv = 0; ni = 0; ns = 0; nc = 4'b0011; na = 0; nb = 0; nim = 0; nsh = 0;
        end else if (flush) begin
            nv = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            d = ref_decode(instr);
            nv = 1; ni = d[5]; ns = d[4]; nc = d[3:0];
            na = ref_fwd(instr[25:21], rs_data);
            nb = ref_fwd(instr[20:16], rt_data);
            nim = instr[15:0]; nsh = instr[10:6];
        end else if (m_valid && out_ready) begin
            nv = 0;
        end
        @(posedge clk);
        m_valid = nv; m_ill = ni; m_src = ns; m_ctl = nc;
        m_a = na; m_b = nb; m_imm = nim; m_sh = nsh;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(1, 32'h2008FFFF, 32'h55, 32'h66, 0, 0, 0, 0, 1);
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b exp 0", out_valid);
        end
        n_vec++;
        if (alu_control !== 4'b0011) begin
            n_err++; $display("FAIL reset_ctl: got %b exp 0011", alu_control);
        end
        n_vec++;
        if (dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL reset_all: got %h exp %h", dut_pack, exp_pack());
        end
        rst_n = 1;
    endtask

    task automatic test_addi();
        drive(1, 32'h2008FFFF, 32'hAAAA0001, 32'hBBBB0002, 0, 0, 0, 0, 1);
        tick();
        n_vec++;
        if ({out_valid, alu_control, ALUSrc, imme} !== {1'b1, 4'b0010, 1'b1, 16'hFFFF}) begin
            n_err++; $display("FAIL addi_fields: got %h exp %h",
                              {out_valid, alu_control, ALUSrc, imme}, {1'b1, 4'b0010, 1'b1, 16'hFFFF});
        end
        n_vec++;
        if (dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL addi_all: got %h exp %h", dut_pack, exp_pack());
        end
    endtask

    task automatic test_sll();
        drive(1, 32'h00084880, 32'h1, 32'h2, 0, 0, 0, 0, 1);
        tick();
        n_vec++;
        if ({alu_control, shamt, ALUSrc} !== {4'b1101, 5'd2, 1'b0}) begin
            n_err++; $display("FAIL sll_fields: got %h exp %h",
                              {alu_control, shamt, ALUSrc}, {4'b1101, 5'd2, 1'b0});
        end
        n_vec++;
        if (dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL sll_all: got %h exp %h", dut_pack, exp_pack());
        end
    endtask

    task automatic test_stall();
        logic [91:0] snap;
        drive(1, 32'h3109000F, 32'h10, 32'h20, 0, 0, 0, 0, 1);   // andi
        tick();
        snap = dut_pack;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h01095022, 32'h77, 32'h88, 0, 0, 0, 0, 0); // sub
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_in_ready: got %b exp 0", in_ready);
            end
            tick();
            n_vec++;
            if (dut_pack !== exp_pack() || dut_pack !== snap) begin
                n_err++; $display("FAIL stall_hold: got %h exp %h", dut_pack, exp_pack());
            end
        end
        drive(1, 32'h01095022, 32'h77, 32'h88, 0, 0, 0, 0, 1);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release: got %b exp 1", in_ready);
        end
        tick();
        n_vec++;
        if (dut_pack !== exp_pack() || alu_control !== 4'b0110) begin
            n_err++; $display("FAIL stall_issue: got %h exp %h", dut_pack, exp_pack());
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL drain: got %h exp %h", dut_pack, exp_pack());
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h35290123, 32'h5, 32'h6, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h01095025, 32'h7, 32'h8, 0, 0, 0, 1, 0);
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL flush: got %h exp %h", dut_pack, exp_pack());
        end
        drive(1, 32'hFC000000, 32'h9, 32'hA, 0, 0, 0, 0, 1);
        tick();
        n_vec++;
        if ({illegal, alu_control, ALUSrc} !== {1'b1, 4'b0011, 1'b0} || dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL illegal_op: got %h exp %h", dut_pack, exp_pack());
        end
    endtask

    task automatic test_forward();
        drive(1, 32'h01094020, 32'hDEAD0000, 32'hBEEF0000, 1, 5'd8, 32'h1234, 0, 1);
        tick();
        n_vec++;
        if (data_a !== 32'h1234 || data_b !== 32'hBEEF0000) begin
            n_err++; $display("FAIL fwd_rs: got %h/%h exp 00001234/beef0000", data_a, data_b);
        end
        drive(1, 32'h01094020, 32'hDEAD0000, 32'hBEEF0000, 1, 5'd9, 32'h5678, 0, 1);
        tick();
        n_vec++;
        if (dut_pack !== exp_pack() || data_b !== 32'h5678) begin
            n_err++; $display("FAIL fwd_rt: got %h exp %h", dut_pack, exp_pack());
        end
        drive(1, 32'h00004020, 32'hCAFE0001, 32'hCAFE0002, 1, 5'd0, 32'h9999, 0, 1);
        tick();
        n_vec++;
        if (data_a !== 32'hCAFE0001 || dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL fwd_r0: got %h exp %h", dut_pack, exp_pack());
        end
    endtask

    task automatic test_mul();
        logic [5:0] exp_code;
`ifdef ALU_MUL_EN
        exp_code = {1'b0, 1'b0, 4'b1111};
`else
        exp_code = {1'b1, 1'b0, 4'b0011};
`endif
        drive(1, 32'h70421002, 32'h3, 32'h4, 0, 0, 0, 0, 1);
        tick();
        n_vec++;
        if ({illegal, ALUSrc, alu_control} !== exp_code || dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL mul_decode: got %h exp %h", dut_pack, exp_pack());
        end
        drive(1, 32'h00000000, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        tick();
        n_vec++;
        if ({illegal, alu_control} !== {1'b0, 4'b1101} || dut_pack !== exp_pack()) begin
            n_err++; $display("FAIL nop_decode: got %h exp %h", dut_pack, exp_pack());
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                                 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h1C};
        logic [5:0] fns [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                 6'h2A, 6'h00, 6'h02, 6'h03, 6'h3F};
        logic [31:0] w;
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) != 0) begin
                w[31:26] = ops[$urandom_range(0, 11)];
                w[25:21] = 5'($urandom_range(0, 3));
                w[20:16] = 5'($urandom_range(0, 3));
                if (w[31:26] == 6'h00 || w[31:26] == 6'h1C) w[5:0] = fns[$urandom_range(0, 11)];
            end
            drive($urandom_range(0, 9) < 7, w, $urandom, $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
            n_vec++;
            if (in_ready !== (!m_valid || out_ready)) begin
                n_err++; $display("FAIL rand_in_ready %0d: got %b exp %b", i, in_ready, !m_valid || out_ready);
            end
            tick();
            n_vec++;
            if (dut_pack !== exp_pack()) begin
                n_err++; $display("FAIL rand_out %0d: got %h exp %h", i, dut_pack, exp_pack());
            end
        end
    endtask

    initial begin
        rst_n = 0;
        m_valid = 0; m_ill = 0; m_src = 0; m_ctl = 4'b0011;
        m_a = 0; m_b = 0; m_imm = 0; m_sh = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_addi();
        test_sll();
        test_stall();
        test_flush();
        test_forward();
        test_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
